// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM states, parity
// encodings and the data-bit clamp used when a frame's width is latched.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam logic [3:0] NBITS_MIN = 4'd5;
    localparam logic [3:0] NBITS_MAX = 4'd9;

    function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input logic [3:0] hi);
        if (n < NBITS_MIN) return NBITS_MIN;
        if (n > hi)        return hi;
        return n;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Valid/ready word channel from the UART receiver to its consumer; the word
// carries the frame's error flags alongside the data.
interface uart_rx_param_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] RxData;
    logic              RxValid;
    logic              RxReady;
    logic              FrameErr;
    logic              ParityErr;

    modport master (output RxData, RxValid, FrameErr, ParityErr, input RxReady);
    modport slave  (input RxData, RxValid, FrameErr, ParityErr, output RxReady);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-Clk pulse every max(div,1) cycles, with a
// synchronous restart so tick phase can be aligned to an external edge.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // Divisors 0 and 1 both give a tick on every Clk.
    assign last = (div < DIV_W'(2)) ? '0 : div - 1'b1;
    assign tick = !restart && (cnt >= last);

    always_ff @(posedge Clk) begin
        if (Rst || restart)  cnt <= '0;
        else if (cnt >= last) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: Rx synchroniser, 3-sample majority vote per bit,
// runtime width/parity, valid/ready output with overrun. `RX_BURST_COUNT_EN adds BurstCount.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVS         = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
`ifdef RX_BURST_COUNT_EN
    ,
    parameter int IDLE_GAP    = 1_000_000
`endif
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             RxEn,
    input  logic             Rx,
    input  logic [DIV_W-1:0] BaudDiv,
    input  logic [3:0]       NBits,
    input  logic [1:0]       ParityMode,
    uart_rx_param_if.master  rx_if,
    output logic             Overrun,
    output logic             Busy
`ifdef RX_BURST_COUNT_EN
    ,
    output logic [7:0]       BurstCount
`endif
);
    localparam int OSW = $clog2(OVS);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVS - 1);
    localparam logic [OSW-1:0] OS_V0   = OSW'(OVS / 2 - 1);
    localparam logic [OSW-1:0] OS_V1   = OSW'(OVS / 2);
    localparam logic [OSW-1:0] OS_V2   = OSW'(OVS / 2 + 1);
    localparam logic [3:0]     NB_HI   = (DATA_W > int'(NBITS_MAX)) ? NBITS_MAX : 4'(DATA_W);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs, rs_prev, fall, start_go, tick;

    rx_state_e         state;
    logic [OSW-1:0]    os_cnt;
    logic [3:0]        bit_cnt, nb_q;
    logic [1:0]        pm_q;
    logic              s0, s1, vote, par_acc, perr_acc;
    logic [DATA_W-1:0] shreg;
    logic              stop_vote, load_ok;

    logic [DATA_W-1:0] data_q;
    logic              valid_q, ferr_q, perr_q, ovr_q;

    always_ff @(posedge Clk) begin
        if (Rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
    end
    assign rs = sync_q[SYNC_STAGES-1];

    assign fall     = rs_prev && !rs;
    assign start_go = (state == ST_IDLE) && RxEn && fall;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .Clk     (Clk),
        .Rst     (Rst),
        .restart (start_go),
        .div     (BaudDiv),
        .tick    (tick)
    );

    // The third sample is taken live, so the vote resolves on the OS_V2 tick.
    assign vote      = (s0 & s1) | (s0 & rs) | (s1 & rs);
    assign stop_vote = (state == ST_STOP) && tick && (os_cnt == OS_V2);
    assign load_ok   = !valid_q || rx_if.RxReady;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            rs_prev  <= 1'b1;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            nb_q     <= NBITS_MIN;
            pm_q     <= PAR_NONE;
            s0       <= 1'b0;
            s1       <= 1'b0;
            par_acc  <= 1'b0;
            perr_acc <= 1'b0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            rs_prev <= rs;
            if (valid_q && rx_if.RxReady) begin
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end

            if (state == ST_IDLE) begin
                if (start_go) begin
                    state    <= ST_START;
                    os_cnt   <= '0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                    par_acc  <= 1'b0;
                    perr_acc <= 1'b0;
                    nb_q     <= clamp_nbits(NBits, NB_HI);
                    pm_q     <= ParityMode;
                end
            end else if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
                if (os_cnt == OS_V0) s0 <= rs;
                if (os_cnt == OS_V1) s1 <= rs;

                case (state)
                    ST_START: begin
                        if (os_cnt == OS_V2 && vote) state <= ST_IDLE;
                        else if (os_cnt == OS_LAST)  state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (os_cnt == OS_V2) begin
                            for (int i = 0; i < DATA_W; i++)
                                if (bit_cnt == 4'(i)) shreg[i] <= vote;
                            par_acc <= par_acc ^ vote;
                        end
                        if (os_cnt == OS_LAST) begin
                            if (bit_cnt == nb_q - 4'd1) begin
                                bit_cnt <= '0;
                                state   <= (pm_q == PAR_EVEN || pm_q == PAR_ODD) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (os_cnt == OS_V2)   perr_acc <= vote ^ par_acc ^ (pm_q == PAR_ODD);
                        if (os_cnt == OS_LAST) state    <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Leave at mid stop bit so a back-to-back start edge is still seen.
                        if (os_cnt == OS_V2) begin
                            state <= ST_IDLE;
                            if (load_ok) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                                ferr_q  <= !vote;
                                perr_q  <= perr_acc;
                            end else begin
                                ovr_q   <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx_if.RxData    = data_q;
    assign rx_if.RxValid   = valid_q;
    assign rx_if.FrameErr  = ferr_q;
    assign rx_if.ParityErr = perr_q;
    assign Overrun         = ovr_q;
    assign Busy            = (state != ST_IDLE);

`ifdef RX_BURST_COUNT_EN
    localparam int GAP_W = $clog2(IDLE_GAP + 2);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(IDLE_GAP + 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_seen;
    logic [7:0]       burst_q;

    // Any low rs (including every start edge) breaks the idle run.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            gap_cnt  <= '0;
            gap_seen <= 1'b0;
            burst_q  <= '0;
        end else begin
            if (!rs)                   gap_cnt <= '0;
            else if (gap_cnt != GAP_SAT) gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt == GAP_SAT)    gap_seen <= 1'b1;
            if (stop_vote && load_ok) begin
                gap_seen <= 1'b0;
                if (gap_seen)               burst_q <= 8'd1;
                else if (burst_q != 8'hFF)  burst_q <= burst_q + 8'd1;
            end
        end
    end
    assign BurstCount = burst_q;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed frame table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_uart_rx_param;
    localparam int DATA_W = 8, OVS = 16, DIV_W = 16, SYNC_STAGES = 2;

    logic             Clk = 1'b0, Rst = 1'b1, RxEn = 1'b0, Rx = 1'b1;
    logic [DIV_W-1:0] BaudDiv = 16'd4;
    logic [3:0]       NBits = 4'd8;
    logic [1:0]       ParityMode = 2'd0;
    logic             Overrun, Busy;
`ifdef RX_BURST_COUNT_EN
    logic [7:0]       BurstCount;
`endif

    uart_rx_param_if #(.DATA_W(DATA_W)) rx_if ();

    uart_rx_param #(
        .DATA_W(DATA_W), .OVS(OVS), .DIV_W(DIV_W), .SYNC_STAGES(SYNC_STAGES)
`ifdef RX_BURST_COUNT_EN
        , .IDLE_GAP(1000)
`endif
    ) dut (
        .Clk(Clk), .Rst(Rst), .RxEn(RxEn), .Rx(Rx), .BaudDiv(BaudDiv),
        .NBits(NBits), .ParityMode(ParityMode), .rx_if(rx_if),
        .Overrun(Overrun), .Busy(Busy)
`ifdef RX_BURST_COUNT_EN
        , .BurstCount(BurstCount)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    typedef struct { logic [DATA_W-1:0] d; logic fe; logic pe; } word_t;
    word_t q[$];
    int    t_rise = 0, t_start = 0;
    logic  vprev = 1'b0;

    always @(negedge Clk) begin
        if (rx_if.RxValid && rx_if.RxReady) q.push_back('{rx_if.RxData, rx_if.FrameErr, rx_if.ParityErr});
        if (rx_if.RxValid && !vprev) t_rise = cyc;
        vprev = rx_if.RxValid;
    end

    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic int model_nb(input int n);
        if (n < 5) return 5;
        if (n > DATA_W) return DATA_W;
        return n;
    endfunction

    function automatic int bit_period();
        return OVS * ((BaudDiv < 2) ? 1 : int'(BaudDiv));
    endfunction

    // Drives one frame on Rx; parity bit follows the even/odd rule, optionally flipped.
    task automatic send_frame(input logic [7:0] data, input int nb, input logic [1:0] pm,
                              input logic flip, input logic stopb);
        int   bp;
        logic p;
        bp = bit_period();
        p  = 1'b0;
        @(posedge Clk); #1;
        Rx = 1'b0; t_start = cyc;
        wait_clk(bp);
        for (int i = 0; i < nb; i++) begin
            Rx = data[i]; p ^= data[i];
            wait_clk(bp);
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            Rx = p ^ (pm == 2'd2) ^ flip;
            wait_clk(bp);
        end
        Rx = stopb;
        wait_clk(bp);
        Rx = 1'b1;
    endtask

    task automatic run_frame(input string nm, input logic [7:0] data, input logic [3:0] nbraw,
                             input logic [1:0] pm, input logic flip, input logic stopb,
                             input logic [7:0] exp_d, input logic exp_fe, input logic exp_pe);
        word_t w;
        NBits = nbraw; ParityMode = pm;
        q.delete();
        send_frame(data, model_nb(int'(nbraw)), pm, flip, stopb);
        wait_clk(4);
        chk({nm, " words"}, q.size(), 1);
        if (q.size() >= 1) begin
            w = q.pop_front();
            chk({nm, " data"}, w.d, exp_d);
            chk({nm, " ferr"}, w.fe, exp_fe);
            chk({nm, " perr"}, w.pe, exp_pe);
        end
    endtask

    typedef struct {
        logic [7:0] data; logic [3:0] nbits; logic [1:0] pm; logic flip; logic stopb;
        logic [7:0] exp_d; logic exp_fe; logic exp_pe;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bp, lat, lo, hi, g;
        logic [7:0] d;
        logic [3:0] nbr;
        logic [1:0] pm;
        logic flip, stopb;
        int nb;

        tbl[0] = '{8'hA5, 4'd8,  2'd0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h35, 4'd7,  2'd1, 1'b0, 1'b1, 8'h35, 1'b0, 1'b0};
        tbl[2] = '{8'h35, 4'd7,  2'd1, 1'b1, 1'b1, 8'h35, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 4'd8,  2'd0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
        tbl[4] = '{8'hFF, 4'd2,  2'd2, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
        tbl[5] = '{8'h96, 4'd15, 2'd3, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0};
        tbl[6] = '{8'h4B, 4'd8,  2'd2, 1'b1, 1'b1, 8'h4B, 1'b0, 1'b1};
        tbl[7] = '{8'hC3, 4'd6,  2'd1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1};

        rx_if.RxReady = 1'b1;
        wait_clk(3);
        chk("reset valid", rx_if.RxValid, 0);
        chk("reset data", rx_if.RxData, 0);
        chk("reset ferr", rx_if.FrameErr, 0);
        chk("reset perr", rx_if.ParityErr, 0);
        chk("reset overrun", Overrun, 0);
        chk("reset busy", Busy, 0);
        Rst = 1'b0; RxEn = 1'b1;
        wait_clk(5);

        // 8N1 0xA5 at BaudDiv=4; delivery lands near the middle of the stop bit.
        run_frame("a5", 8'hA5, 4'd8, 2'd0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
        lat = t_rise - t_start;
        lo  = (9 * OVS + OVS / 2) * 4;
        hi  = (9 * OVS + OVS / 2 + 2) * 4 + SYNC_STAGES + 2;
        nvec++;
        if (lat < lo || lat > hi) begin
            nerr++;
            $display("FAIL latency: got %0d expected %0d..%0d", lat, lo, hi);
        end

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].nbits, tbl[i].pm, tbl[i].flip,
                      tbl[i].stopb, tbl[i].exp_d, tbl[i].exp_fe, tbl[i].exp_pe);
        chk("no overrun with ready", Overrun, 0);

        // One-tick low glitch: false start, no word.
        q.delete(); NBits = 4'd8; ParityMode = 2'd0;
        @(posedge Clk); #1; Rx = 1'b0;
        wait_clk(4); Rx = 1'b1;
        wait_clk(8);
        chk("glitch busy", Busy, 1);
        wait_clk(OVS * 4);
        chk("glitch busy clear", Busy, 0);
        chk("glitch words", q.size(), 0);

        // RxEn low: start ignored. RxEn dropped mid-frame: frame still completes.
        RxEn = 1'b0;
        q.delete();
        send_frame(8'h77, 8, 2'd0, 1'b0, 1'b1);
        wait_clk(4);
        chk("rxen off words", q.size(), 0);
        RxEn = 1'b1;
        fork
            run_frame("rxen mid", 8'h6E, 4'd8, 2'd0, 1'b0, 1'b1, 8'h6E, 1'b0, 1'b0);
            begin wait_clk(200); RxEn = 1'b0; end
        join
        RxEn = 1'b1;

        // Overrun: second frame dropped while first is unconsumed.
        rx_if.RxReady = 1'b0;
        q.delete();
        send_frame(8'h11, 8, 2'd0, 1'b0, 1'b1); wait_clk(4);
        send_frame(8'h22, 8, 2'd0, 1'b0, 1'b1); wait_clk(4);
        chk("ovr valid", rx_if.RxValid, 1);
        chk("ovr data", rx_if.RxData, 8'h11);
        chk("ovr flag", Overrun, 1);
        @(posedge Clk); #1; rx_if.RxReady = 1'b1;
        wait_clk(1);
        chk("ovr valid clear", rx_if.RxValid, 0);
        chk("ovr flag clear", Overrun, 0);
        chk("ovr words", q.size(), 1);
        if (q.size() >= 1) chk("ovr kept word", q[0].d, 8'h11);

        // Majority vote: one-tick high glitch over the middle sample of data bit 3.
        q.delete();
        bp = bit_period();
        g  = (OVS / 2 + 1) * 4 - 2;
        @(posedge Clk); #1; Rx = 1'b0;
        wait_clk(bp);
        for (int i = 0; i < 8; i++) begin
            Rx = 1'b0;
            if (i == 3) begin
                wait_clk(g); Rx = 1'b1; wait_clk(4); Rx = 1'b0; wait_clk(bp - g - 4);
            end else begin
                wait_clk(bp);
            end
        end
        Rx = 1'b1; wait_clk(bp + 4);
        chk("vote words", q.size(), 1);
        if (q.size() >= 1) chk("vote data", q[0].d, 8'h00);

        // Reset mid-DATA with a held word and overrun pending.
        rx_if.RxReady = 1'b0;
        send_frame(8'h5A, 8, 2'd0, 1'b0, 1'b1); wait_clk(4);
        send_frame(8'hA6, 8, 2'd0, 1'b0, 1'b1); wait_clk(4);
        chk("pre-reset overrun", Overrun, 1);
        @(posedge Clk); #1; Rx = 1'b0;
        wait_clk(bp * 3);
        chk("pre-reset busy", Busy, 1);
        Rst = 1'b1; Rx = 1'b1;
        wait_clk(1);
        Rst = 1'b0;
        chk("mid reset valid", rx_if.RxValid, 0);
        chk("mid reset data", rx_if.RxData, 0);
        chk("mid reset ferr", rx_if.FrameErr, 0);
        chk("mid reset perr", rx_if.ParityErr, 0);
        chk("mid reset overrun", Overrun, 0);
        chk("mid reset busy", Busy, 0);
        rx_if.RxReady = 1'b1;
        q.delete();
        wait_clk(bp * 12);
        chk("mid reset words", q.size(), 0);

        // Randomized frames against the frame-level model.
        for (int k = 0; k < 24; k++) begin
            BaudDiv = DIV_W'($urandom_range(0, 5));
            d     = 8'($urandom);
            nbr   = 4'($urandom_range(0, 15));
            pm    = 2'($urandom_range(0, 3));
            flip  = ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 4) != 0);
            nb    = model_nb(int'(nbr));
            wait_clk($urandom_range(1, 40));
            run_frame($sformatf("rnd%0d", k), d, nbr, pm, flip, stopb,
                      8'(d & ((1 << nb) - 1)), !stopb, (pm == 2'd1 || pm == 2'd2) ? flip : 1'b0);
        end

`ifdef RX_BURST_COUNT_EN
        BaudDiv = 16'd4;
        wait_clk(2000);
        for (int k = 1; k <= 3; k++) begin
            run_frame($sformatf("burst%0d", k), 8'(8'h40 + k), 4'd8, 2'd0, 1'b0, 1'b1,
                      8'(8'h40 + k), 1'b0, 1'b0);
            chk($sformatf("burst count %0d", k), BurstCount, k);
        end
        wait_clk(2000);
        run_frame("burst gap", 8'h99, 4'd8, 2'd0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        chk("burst count after gap", BurstCount, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
